// File: rtl/store_pkg.sv
// Shared encodings for the store byte-merge path: access sizes, FSM states and lane widths.
package store_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int LANE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/store_lane_merge.sv
// Splices LSB-justified store data into the lane(s) of an old memory word selected by size/addr.
module store_lane_merge
    import store_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] data,
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    output logic [WORD_W-1:0] new_word
);

    always_comb begin
        // NOTE: default first so every path assigns new_word and no latch is inferred.
        new_word = old_word;
        case (size)
            SIZE_B:  new_word[{addr_lo, 3'b000} +: LANE_W]      = data[LANE_W-1:0];
            // Half lane chosen by addr[1] only; addr[0] is ignored when the trap is off.
            SIZE_H:  new_word[{addr_lo[1], 4'b0000} +: HALF_W] = data[HALF_W-1:0];
            default: new_word = data;
        endcase
    end

endmodule

// File: rtl/store_byte_merger.sv
// Store unit for a byte-enable-less word memory: sub-word stores read-modify-write, words write directly.
// Optional feature: define STORE_MISALIGN_TRAP_EN to reject misaligned half/word stores with an err pulse.
module store_byte_merger
    import store_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rd_data,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wr_data,
    output logic              err
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          size_q, size_d;
    logic [1:0]          lo_q, lo_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wr_data_q, wr_data_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;
    logic [WORD_W-1:0]   merged;
    logic                is_word;
    logic                trap;

    // Reserved size 2'b11 shares the word path.
    assign is_word = req_size[1];

`ifdef STORE_MISALIGN_TRAP_EN
    logic err_q, err_d;
    assign trap = ((req_size == SIZE_H) && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    assign err  = err_q;
`else
    assign trap = 1'b0;
    assign err  = 1'b0;
`endif

    store_lane_merge u_merge (
        .old_word (mem_rd_data),
        .data     (data_q),
        .size     (size_q),
        .addr_lo  (lo_q),
        .new_word (merged)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        lo_d      = lo_q;
        data_d    = data_q;
        addr_d    = addr_q;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        wr_data_d = '0;
`ifdef STORE_MISALIGN_TRAP_EN
        err_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (trap) begin
`ifdef STORE_MISALIGN_TRAP_EN
                        err_d = 1'b1;
`endif
                    end else begin
                        size_d = req_size;
                        lo_d   = req_addr[1:0];
                        data_d = req_data;
                        addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                        if (is_word) begin
                            state_d   = ST_WRITE;
                            wr_en_d   = 1'b1;
                            wr_data_d = req_data;
                        end else begin
                            state_d = ST_READ;
                            rd_en_d = 1'b1;
                        end
                    end
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                // Read data is valid in the last WAIT cycle; merge it straight into the write register.
                if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
                    state_d   = ST_WRITE;
                    wr_en_d   = 1'b1;
                    wr_data_d = merged;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            size_q    <= '0;
            lo_q      <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            lo_q      <= lo_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
`ifdef STORE_MISALIGN_TRAP_EN
            err_q     <= err_d;
`endif
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign done        = wr_en_q;
    assign mem_addr    = addr_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = wr_data_q;

endmodule
